imm_ext_pipe: RTL and testbench

Parametrised, registered immediate-extension stage for the MIPS datapath. It generalises the combinational 16→32 sign/zero extender in three ways:
- configurable input and output widths;
- a mode selector covering zero-extend, sign-extend, load-upper placement and branch-offset (sign-extend, shift left 2);
- a valid/ready handshake with a one-entry skid buffer, so it can sit between decode and execute in the pipelined core without breaking the stall path.

---
 rtl/imm_ext_pipe.sv | 78 +++++++
 tb/tb_imm_ext_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender: zero/sign/high/branch-offset modes behind a
// valid/ready handshake with a one-entry skid buffer.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam int PAD_W = OUT_W - IN_W;

  typedef struct packed {
    logic             err;
    logic [OUT_W-1:0] data;
  } res_t;

  res_t             ext;
  res_t             out_q;
  res_t             skid_q;
  logic             skid_valid;
  logic [OUT_W-1:0] sext;
  logic             accept;
  logic             slot_free;

  // Extension happens before the registers, so the mode never needs storing.
  always_comb begin
    sext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
    ext  = '0;
    case (in_mode)
      3'd0:    ext.data = {{PAD_W{1'b0}}, in_imm};
      3'd1:    ext.data = sext;
      3'd2:    ext.data = {in_imm, {PAD_W{1'b0}}};
      3'd3:    ext.data = {sext[OUT_W-3:0], 2'b00};
      default: ext.err  = 1'b1;
    endcase
  end

  assign in_ready  = !rst && !skid_valid;
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (slot_free) begin
      // Skid entry is older than anything upstream, so it always goes first.
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q     <= ext;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= ext;
      skid_valid <= 1'b1;
    end
  end

  assign out_data = out_q.data;
  assign out_err  = out_q.err;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed + scoreboard bench for imm_ext_pipe at 16/32 and 8/12.
module tb_imm_ext_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [15:0] a_in_imm;
  logic [2:0]  a_in_mode;
  logic [31:0] a_out_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [7:0]  b_in_imm;
  logic [2:0]  b_in_mode;
  logic [11:0] b_out_data;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_imm(a_in_imm), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(12)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  bit b_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference model, {err, data}.
  function automatic logic [32:0] ref_ext(input int in_w, input int out_w,
                                          input longint imm, input int mode);
    longint mask, s, d;
    mask = (longint'(1) << out_w) - 1;
    s = imm;
    if (((imm >> (in_w - 1)) & 1) != 0) s = imm - (longint'(1) << in_w);
    case (mode)
      0: d = imm;
      1: d = s & mask;
      2: d = (imm << (out_w - in_w)) & mask;
      3: d = (s * 4) & mask;
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, d[31:0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_a(input logic [15:0] imm, input logic [2:0] mode, input logic [32:0] exp);
    bit done;
    done = 0;
    a_in_valid = 1'b1; a_in_imm = imm; a_in_mode = mode;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (a_in_ready) begin qa.push_back(exp); done = 1; end
      @(posedge clk); #1;
    end
    if (!done) chk("a_send_timeout", 0, 1);
  endtask

  task automatic send_b(input logic [7:0] imm, input logic [2:0] mode, input logic [32:0] exp);
    bit done;
    done = 0;
    b_in_valid = 1'b1; b_in_imm = imm; b_in_mode = mode;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (b_in_ready) begin qb.push_back(exp); done = 1; end
      @(posedge clk); #1;
    end
    if (!done) chk("b_send_timeout", 0, 1);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 40 && qa.size() != 0; i++) cyc(1);
    chk("a_drain_left", qa.size(), 0);
  endtask

  task automatic drain_b();
    for (int i = 0; i < 60 && qb.size() != 0; i++) cyc(1);
    chk("b_drain_left", qb.size(), 0);
  endtask

  // Output monitors: pop on every drain, and check hold-stability under stall.
  initial begin
    logic        stall;
    logic [31:0] hold;
    logic [32:0] e;
    stall = 0; hold = '0;
    forever begin
      @(negedge clk);
      if (stall) begin
        chk("a_stable_data", a_out_data, hold);
        chk("a_stable_valid", a_out_valid, 1);
      end
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_extra_out", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_data", a_out_data, e[31:0]);
          chk("a_err", a_out_err, e[32]);
        end
      end
      stall = a_out_valid && !a_out_ready && !rst;
      hold  = a_out_data;
    end
  end

  initial begin
    logic        stall;
    logic [11:0] hold;
    logic [32:0] e;
    stall = 0; hold = '0;
    forever begin
      @(negedge clk);
      if (stall) begin
        chk("b_stable_data", b_out_data, hold);
        chk("b_stable_valid", b_out_valid, 1);
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_extra_out", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_data", b_out_data, e[11:0]);
          chk("b_err", b_out_err, e[32]);
        end
      end
      stall = b_out_valid && !b_out_ready && !rst;
      hold  = b_out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] imm;
    logic [2:0]  mode;
    logic [32:0] r;

    rst = 1'b1;
    a_in_valid = 1'b1; a_in_imm = 16'h1234; a_in_mode = 3'd1; a_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_imm = 8'h55;    b_in_mode = 3'd1; b_out_ready = 1'b1;

    // Reset held two cycles with input valid
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_out_data", a_out_data, 0);
      chk("rst_out_err", a_out_err, 0);
      chk("rst_in_ready", a_in_ready, 0);
      chk("rst_b_valid", b_out_valid, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", a_in_ready, 1);
    chk("post_rst_b_ready", b_in_ready, 1);
    chk("post_rst_valid", a_out_valid, 0);
    @(posedge clk); #1;

    // Modes, back-to-back
    send_a(16'h8001, 3'd0, {1'b0, 32'h00008001});
    send_a(16'h8001, 3'd1, {1'b0, 32'hFFFF8001});
    send_a(16'h8001, 3'd2, {1'b0, 32'h80010000});
    send_a(16'hFFFF, 3'd3, {1'b0, 32'hFFFFFFFC});
    send_a(16'h1234, 3'd5, {1'b1, 32'h00000000});
    send_a(16'h4001, 3'd3, {1'b0, 32'h00010004});
    send_a(16'h7FFF, 3'd7, {1'b1, 32'h00000000});
    a_in_valid = 1'b0;
    drain_a();

    // Back-pressure: A B C D, stall from the cycle A is visible
    fork
      begin
        send_a(16'h0001, 3'd1, {1'b0, 32'h00000001});
        send_a(16'h8000, 3'd0, {1'b0, 32'h00008000});
        send_a(16'h00FF, 3'd2, {1'b0, 32'h00FF0000});
        send_a(16'h4000, 3'd3, {1'b0, 32'h00010000});
        a_in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 20 && !a_out_valid; i++) begin @(posedge clk); #1; end
        a_out_ready = 1'b0;
        @(negedge clk);
        chk("bp_first_data", a_out_data, 32'h00000001);
        chk("bp_first_ready", a_in_ready, 1);
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_data", a_out_data, 32'h00000001);
          chk("bp_skid_ready", a_in_ready, 0);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
      end
    join
    drain_a();

    // Full throughput against the model
    for (int i = 0; i < 100; i++) begin
      imm  = 16'($urandom);
      mode = 3'($urandom_range(0, 3));
      r    = ref_ext(16, 32, longint'(imm), int'(mode));
      a_in_valid = 1'b1; a_in_imm = imm; a_in_mode = mode;
      @(negedge clk);
      chk("tp_in_ready", a_in_ready, 1);
      if (i > 0) chk("tp_out_valid", a_out_valid, 1);
      if (a_in_ready) qa.push_back(r);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    drain_a();

    // Reset with both entries occupied: everything discarded, no output pulse
    a_out_ready = 1'b0;
    send_a(16'h0011, 3'd0, {1'b0, 32'h00000011});
    send_a(16'h0022, 3'd0, {1'b0, 32'h00000022});
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", a_in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", a_in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; qa.delete(); a_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_pulse", a_out_valid, 0);
      chk("midrst_ready", a_in_ready, 1);
    end
    @(posedge clk); #1;

    // 8/12 instance, directed
    send_b(8'h80, 3'd0, {1'b0, 32'h080});
    send_b(8'h80, 3'd1, {1'b0, 32'hF80});
    send_b(8'h80, 3'd2, {1'b0, 32'h800});
    send_b(8'h80, 3'd3, {1'b0, 32'hE00});
    send_b(8'h7F, 3'd3, {1'b0, 32'h1FC});
    send_b(8'h80, 3'd6, {1'b1, 32'h000});
    b_in_valid = 1'b0;
    drain_b();

    // 8/12 random traffic with random out_ready
    b_done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [7:0] bi;
          logic [2:0] bm;
          bi = 8'($urandom);
          bm = 3'($urandom_range(0, 3));
          send_b(bi, bm, ref_ext(8, 12, longint'(bi), int'(bm)));
        end
        b_in_valid = 1'b0;
        b_done = 1;
      end
      begin
        for (int i = 0; i < 2000 && !b_done; i++) begin
          @(posedge clk); #1;
          b_out_ready = 1'($urandom_range(0, 1));
        end
        b_out_ready = 1'b1;
      end
    join
    b_out_ready = 1'b1;
    drain_b();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
